stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr_if.sv | 30 +++
 rtl/stream_mux_rr.sv | 121 ++++++++++++
 tb/tb_stream_mux_rr.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
// Bundle of the N input streams, the merged output stream and the arbiter status
// signals of stream_mux_rr. The slave modport is the mux side.
interface stream_mux_rr_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_last;
  logic               out_ready;
  logic [SELW-1:0]    grant;
  logic               busy;

  modport master (
    output in_data, in_valid, in_last, sel, out_ready,
    input  in_ready, out_data, out_valid, out_last, grant, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, sel, out_ready,
    output in_ready, out_data, out_valid, out_last, grant, busy
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-way packet-locking stream mux with round-robin or external-select arbitration
// and a single registered output stage.
module stream_mux_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter bit RR    = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int SELW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [SELW-1:0]   grant_q, grant_d;
  logic [SELW-1:0]   cand, scan, src;
  logic              cand_ok;
  logic              can_load;
  logic              load;
  logic [N-1:0]      ready_d;

  logic [WIDTH-1:0]  data_p1;
  logic              last_p1;
  logic              vld_p1;

  assign can_load = !vld_p1 || bus.out_ready;

  // Candidate for a new packet; only consulted while no packet is open.
  always_comb begin
    cand_ok = 1'b0;
    cand    = '0;
    scan    = '0;
    if (RR) begin
      // Walk downward so the nearest valid channel after ptr is the one left standing.
      for (int k = N; k >= 1; k--) begin
        scan = SELW'((int'(ptr_q) + k) % N);
        if (bus.in_valid[scan]) begin
          cand_ok = 1'b1;
          cand    = scan;
        end
      end
    end else if (int'(bus.sel) < N) begin
      if (bus.in_valid[bus.sel]) begin
        cand_ok = 1'b1;
        cand    = bus.sel;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ready_d = '0;
    load    = 1'b0;
    src     = grant_q;
    case (state_q)
      IDLE: begin
        if (cand_ok && can_load) begin
          ready_d[cand] = 1'b1;
          load          = 1'b1;
          src           = cand;
          grant_d       = cand;
          if (bus.in_last[cand]) ptr_d   = cand;
          else                   state_d = LOCK;
        end
      end
      LOCK: begin
        ready_d[grant_q] = can_load;
        if (can_load && bus.in_valid[grant_q]) begin
          load = 1'b1;
          if (bus.in_last[grant_q]) begin
            state_d = IDLE;
            ptr_d   = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= SELW'(N - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Output stage boundary (p1): one beat of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= bus.in_data[src*WIDTH +: WIDTH];
      last_p1 <= bus.in_last[src];
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.in_ready  = ready_d;
  assign bus.out_data  = data_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_last  = last_p1;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == LOCK);
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a round-robin instance checked every cycle against a
// packet-level model, plus an external-select instance with directed checks.
module tb_stream_mux_rr;
  localparam int W  = 16;
  localparam int NM = 4;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(W), .N(NM)) if_rr ();
  stream_mux_rr_if #(.WIDTH(W), .N(NS)) if_sel ();

  stream_mux_rr #(.WIDTH(W), .N(NM), .RR(1'b1)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_rr.slave)
  );

  stream_mux_rr #(.WIDTH(W), .N(NS), .RR(1'b0)) u_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_sel.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-channel beat queues {last,data}; the driver presents the head of each.
  logic [16:0]   bmem [NM][32];
  int            head [NM];
  int            tail [NM];
  logic [NM-1:0] acc;

  task automatic push(input int ch, input logic [15:0] d, input logic l);
    bmem[ch][tail[ch]] = {l, d};
    tail[ch]++;
  endtask

  function automatic bit queues_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NM; i++) if (head[i] != tail[i]) e = 1'b0;
    return e;
  endfunction

  initial begin
    if_rr.in_valid = '0;
    if_rr.in_last  = '0;
    if_rr.in_data  = '0;
    forever begin
      @(negedge clk);
      acc = rst_n ? (if_rr.in_valid & if_rr.in_ready) : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NM; i++) begin
        if (acc[i] && head[i] < tail[i]) head[i]++;
        if (head[i] < tail[i]) begin
          if_rr.in_valid[i]         = 1'b1;
          if_rr.in_last[i]          = bmem[i][head[i]][16];
          if_rr.in_data[i*W +: W]   = bmem[i][head[i]][15:0];
        end else begin
          if_rr.in_valid[i]         = 1'b0;
          if_rr.in_last[i]          = 1'b0;
          if_rr.in_data[i*W +: W]   = '0;
        end
      end
    end
  end

  // Packet-level model: which channel owns the output (open packet, or the
  // first requester after the last finished packet) and what the register holds.
  logic          m_vld, m_last;
  logic [15:0]   m_data;
  int            m_grant, m_open, m_ptr, m_c;
  logic [NM-1:0] m_er, m_tx;
  logic [16:0]   log_q [$];

  initial begin
    m_vld = 1'b0; m_last = 1'b0; m_data = '0;
    m_grant = 0; m_open = -1; m_ptr = NM - 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_vld = 1'b0; m_last = 1'b0; m_data = '0;
        m_grant = 0; m_open = -1; m_ptr = NM - 1;
      end else begin
        m_er = '0;
        if (!m_vld || if_rr.out_ready) begin
          if (m_open >= 0) m_er[m_open] = 1'b1;
          else begin
            for (int k = 1; k <= NM; k++) begin
              m_c = (m_ptr + k) % NM;
              if (if_rr.in_valid[m_c]) begin
                m_er[m_c] = 1'b1;
                break;
              end
            end
          end
        end
        check("in_ready", 32'(if_rr.in_ready), 32'(m_er));
        check("out_valid", 32'(if_rr.out_valid), 32'(m_vld));
        check("grant", 32'(if_rr.grant), 32'(m_grant));
        check("busy", 32'(if_rr.busy), 32'(m_open >= 0));
        if (m_vld) begin
          check("out_data", 32'(if_rr.out_data), 32'(m_data));
          check("out_last", 32'(if_rr.out_last), 32'(m_last));
        end
        if (if_rr.out_valid && if_rr.out_ready)
          log_q.push_back({if_rr.out_last, if_rr.out_data});
        m_tx = m_er & if_rr.in_valid;
        if (m_tx != '0) begin
          for (int i = 0; i < NM; i++) if (m_tx[i]) m_c = i;
          m_data  = if_rr.in_data[m_c*W +: W];
          m_last  = if_rr.in_last[m_c];
          m_vld   = 1'b1;
          m_grant = m_c;
          if (m_last) begin
            m_open = -1;
            m_ptr  = m_c;
          end else begin
            m_open = m_c;
          end
        end else if (if_rr.out_ready) begin
          m_vld = 1'b0;
        end
      end
    end
  end

  logic [16:0] ev [8];

  task automatic check_log(input string name, input int n);
    check({name, "_len"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check(name, (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF, 32'(ev[i]));
  endtask

  task automatic wait_idle(input int budget, input bit toggle);
    int n;
    logic [7:0] pat;
    n   = 0;
    pat = 8'b1011_0110;
    while (!(queues_empty() && !if_rr.out_valid) && n < budget) begin
      if (toggle) if_rr.out_ready = pat[n % 8];
      @(posedge clk);
      #2;
      n++;
    end
    if_rr.out_ready = 1'b1;
    check("drain", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n           = 1'b0;
    if_rr.out_ready = 1'b1;
    if_rr.sel       = '0;
    if_sel.in_data  = '0;
    if_sel.in_valid = '0;
    if_sel.in_last  = '0;
    if_sel.sel      = '0;
    if_sel.out_ready = 1'b1;
    for (int i = 0; i < NM; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(if_rr.out_valid), 32'd0);
    check("rst_out_data",  32'(if_rr.out_data),  32'd0);
    check("rst_out_last",  32'(if_rr.out_last),  32'd0);
    check("rst_grant",     32'(if_rr.grant),     32'd0);
    check("rst_busy",      32'(if_rr.busy),      32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // All channels requesting single-beat packets: grants rotate 0,1,2,3,0.
    @(posedge clk);
    #2;
    log_q.delete();
    push(0, 16'hA000, 1'b1); push(1, 16'hA001, 1'b1);
    push(2, 16'hA002, 1'b1); push(3, 16'hA003, 1'b1);
    push(0, 16'hA004, 1'b1);
    wait_idle(40, 1'b0);
    ev = '{17'h1A000, 17'h1A001, 17'h1A002, 17'h1A003, 17'h1A004, 17'h0, 17'h0, 17'h0};
    check_log("rr_rotate", 5);

    // Reset in the middle of a packet from ch1.
    @(posedge clk);
    #2;
    for (int k = 0; k < 5; k++) push(1, 16'h1501 + 16'(k), k == 4);
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy",  32'(if_rr.busy),  32'd1);
    check("mid_grant", 32'(if_rr.grant), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(if_rr.out_valid), 32'd0);
    check("arst_busy",      32'(if_rr.busy),      32'd0);
    check("arst_grant",     32'(if_rr.grant),     32'd0);
    for (int i = 0; i < NM; i++) head[i] = tail[i];
    @(posedge clk);
    #3 rst_n = 1'b1;

    // ch1 3-beat packet locks out ch2 until its last beat.
    @(posedge clk);
    #2;
    log_q.delete();
    push(1, 16'h1111, 1'b0); push(1, 16'h1112, 1'b0); push(1, 16'h1113, 1'b1);
    push(2, 16'h2222, 1'b1);
    wait_idle(40, 1'b0);
    ev = '{17'h01111, 17'h01112, 17'h11113, 17'h12222, 17'h0, 17'h0, 17'h0, 17'h0};
    check_log("rr_lock", 4);

    // Backpressure: ABCD held while out_ready is low.
    @(posedge clk);
    #2;
    log_q.delete();
    if_rr.out_ready = 1'b0;
    push(0, 16'hABCD, 1'b1); push(0, 16'h0B01, 1'b1);
    n = 0;
    while (!if_rr.out_valid && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("bp_fill", 32'(n < 10), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_data",  32'(if_rr.out_data), 32'hABCD);
      check("bp_ready", 32'(if_rr.in_ready), 32'd0);
    end
    @(posedge clk);
    #2;
    if_rr.out_ready = 1'b1;
    wait_idle(20, 1'b0);
    ev = '{17'h1ABCD, 17'h10B01, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
    check_log("bp_order", 2);

    // Mixed packets under a toggling out_ready; ptr is at ch0 so ch2 goes first.
    @(posedge clk);
    #2;
    log_q.delete();
    push(0, 16'h0001, 1'b0); push(0, 16'h0002, 1'b1);
    push(2, 16'h2201, 1'b0); push(2, 16'h2202, 1'b0); push(2, 16'h2203, 1'b1);
    push(3, 16'h3301, 1'b1);
    wait_idle(60, 1'b1);
    ev = '{17'h02201, 17'h02202, 17'h12203, 17'h13301, 17'h00001, 17'h10002, 17'h0, 17'h0};
    check_log("rr_mix", 6);

    // External select, N=3: sel change mid-packet is ignored, then sel=3 grants nothing.
    @(posedge clk);
    #2;
    if_sel.sel      = 2'd2;
    if_sel.in_valid = 3'b101;
    if_sel.in_last  = 3'b001;
    if_sel.in_data  = {16'h5201, 16'h0000, 16'h5001};
    @(negedge clk);
    check("sel_ready_first", 32'(if_sel.in_ready), 32'b100);
    @(posedge clk);
    #2;
    if_sel.sel = 2'd0;
    if_sel.in_last = 3'b101;
    if_sel.in_data[2*W +: W] = 16'h5202;
    @(negedge clk);
    check("sel_ready_locked", 32'(if_sel.in_ready), 32'b100);
    check("sel_busy",         32'(if_sel.busy),     32'd1);
    check("sel_grant2",       32'(if_sel.grant),    32'd2);
    check("sel_beat1",        32'(if_sel.out_data), 32'h5201);
    check("sel_beat1_last",   32'(if_sel.out_last), 32'd0);
    @(posedge clk);
    #2;
    if_sel.in_valid = 3'b001;
    @(negedge clk);
    check("sel_beat2",      32'(if_sel.out_data), 32'h5202);
    check("sel_beat2_last", 32'(if_sel.out_last), 32'd1);
    check("sel_idle_busy",  32'(if_sel.busy),     32'd0);
    check("sel_ready_ch0",  32'(if_sel.in_ready), 32'b001);
    @(posedge clk);
    #2;
    if_sel.sel      = 2'd3;
    if_sel.in_valid = 3'b111;
    @(negedge clk);
    check("sel_ch0_data",  32'(if_sel.out_data),  32'h5001);
    check("sel_ch0_valid", 32'(if_sel.out_valid), 32'd1);
    check("sel_grant0",    32'(if_sel.grant),     32'd0);
    check("sel_oor_ready", 32'(if_sel.in_ready),  32'd0);
    @(posedge clk);
    #2;
    repeat (10) begin
      @(negedge clk);
      check("oor_ready", 32'(if_sel.in_ready),  32'd0);
      check("oor_valid", 32'(if_sel.out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
